// File: rtl/overlay_frame_ctrl.sv
// -----------------------------------------------------------------------------
// overlay_frame_ctrl
//
// Frame-level sequencer for the 128x128 image-overlay generator. Corner sets
// from the marker detector are sanity-checked and compared with the previous
// accepted set. A set counts as a match when every coordinate moved by no more
// than TOL. Once STABLE_FRAMES consecutive frames match, the block locks. It
// then publishes the corners to the generator, but only at frame boundaries,
// so the overlay never tears mid-frame. Lock is dropped after LOST_FRAMES
// consecutive frames in which no valid set was seen.
//
// Ports
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_frame_start         one-cycle pulse at the first pixel of each frame
//   i_corner_valid        one-cycle pulse, i_ul/i_ur/i_dl/i_dr are valid
//   i_ul,i_ur,i_dl,i_dr   corners {row[19:10], col[9:0]}
//   i_enable_sw           user overlay enable (synchronised level)
//   i_pause_sw            user freeze (level)
//   o_addr_valid          one-cycle publish pulse, one cycle after i_frame_start
//   o_*_addr              published corners (held between publishes)
//   o_enable              overlay enable sampled together with o_addr_valid
//   o_locked              high while in LOCKED
//   o_stab_cnt            current stability count (debug)
// -----------------------------------------------------------------------------
module overlay_frame_ctrl #(
    parameter int TOL           = 8,
    parameter int STABLE_FRAMES = 3,
    parameter int LOST_FRAMES   = 4,
    parameter int CNT_W         = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_frame_start,
    input  logic             i_corner_valid,
    input  logic [19:0]      i_ul,
    input  logic [19:0]      i_ur,
    input  logic [19:0]      i_dl,
    input  logic [19:0]      i_dr,
    input  logic             i_enable_sw,
    input  logic             i_pause_sw,
    output logic             o_addr_valid,
    output logic [19:0]      o_ul_addr,
    output logic [19:0]      o_ur_addr,
    output logic [19:0]      o_dl_addr,
    output logic [19:0]      o_dr_addr,
    output logic             o_enable,
    output logic             o_locked,
    output logic [CNT_W-1:0] o_stab_cnt
);

    typedef enum logic [1:0] {IDLE, SEARCH, LOCKED} state_t;

    localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(STABLE_FRAMES);
    localparam logic [CNT_W-1:0] LOST_MAX   = CNT_W'(LOST_FRAMES);
    localparam logic [10:0]      TOL_W      = 11'(TOL);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] stab_reg, stab_next;
    logic [CNT_W-1:0] miss_reg, miss_next;
    logic             seen_reg, seen_next;
    logic             match_reg, match_next;
    logic             locked_reg;
    logic [19:0]      cand_reg [4];
    logic [19:0]      out_reg  [4];
    logic             addr_valid_reg;
    logic             enable_reg;

    logic             pub;        // publish on this edge
    logic             pub_cand;   // publish loads the candidate corners
    logic             pub_en;     // enable value that goes with the publish

    logic [19:0]      new_c [4];
    logic [3:0]       corner_ok;
    logic             sane;
    logic             accept;
    logic             all_match;
    logic             frame_eval;

    assign new_c[0] = i_ul;
    assign new_c[1] = i_ur;
    assign new_c[2] = i_dl;
    assign new_c[3] = i_dr;

    // Absolute difference widened to 11 bits, so no unsigned wrap occurs.
    function automatic logic [10:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
        logic [10:0] ea;
        logic [10:0] eb;
        ea = {1'b0, a};
        eb = {1'b0, b};
        return (ea >= eb) ? (ea - eb) : (eb - ea);
    endfunction

    // Per-corner tolerance check on row and column.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_match
            assign corner_ok[gi] =
                (abs_diff(new_c[gi][19:10], cand_reg[gi][19:10]) <= TOL_W) &&
                (abs_diff(new_c[gi][9:0],   cand_reg[gi][9:0])   <= TOL_W);
        end
    endgenerate

    assign all_match = &corner_ok;

    // Geometry check: left of right on both edges, top above bottom on both sides.
    assign sane = (i_ul[9:0]   < i_ur[9:0])   &&
                  (i_dl[9:0]   < i_dr[9:0])   &&
                  (i_ul[19:10] < i_dl[19:10]) &&
                  (i_ur[19:10] < i_dr[19:10]);

    assign accept     = i_corner_valid && sane;
    assign frame_eval = i_frame_start && !i_pause_sw;

    // Next-state, counters and publish decision
    always_comb begin
        state_next = state_reg;
        stab_next  = stab_reg;
        miss_next  = miss_reg;
        seen_next  = seen_reg;
        match_next = match_reg;
        pub        = 1'b0;
        pub_cand   = 1'b0;
        pub_en     = enable_reg;

        if (frame_eval) begin
            if (seen_reg && match_reg) begin
                stab_next = (stab_reg >= STABLE_MAX) ? STABLE_MAX : stab_reg + 1'b1;
                miss_next = '0;
            end else if (seen_reg) begin
                stab_next = CNT_W'(1);
                miss_next = '0;
            end else begin
                miss_next = (miss_reg >= LOST_MAX) ? LOST_MAX : miss_reg + 1'b1;
                stab_next = '0;
            end
            seen_next = 1'b0;

            // Decisions use the counter values computed in this cycle.
            case (state_reg)
                IDLE: begin
                    if (i_enable_sw) state_next = SEARCH;
                end
                SEARCH: begin
                    if (!i_enable_sw) begin
                        state_next = IDLE;
                    end else if (stab_next == STABLE_MAX) begin
                        pub        = 1'b1;
                        pub_cand   = 1'b1;
                        pub_en     = 1'b1;
                        state_next = LOCKED;
                    end
                end
                LOCKED: begin
                    if (!i_enable_sw) begin
                        pub        = 1'b1;
                        pub_en     = 1'b0;
                        state_next = IDLE;
                    end else if (miss_next == LOST_MAX) begin
                        pub        = 1'b1;
                        pub_en     = 1'b0;
                        stab_next  = '0;
                        state_next = SEARCH;
                    end else if (seen_reg && match_reg) begin
                        pub      = 1'b1;
                        pub_cand = 1'b1;
                        pub_en   = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end

        // A sample arriving on the frame edge belongs to the new frame. The
        // evaluation above still used the old flags.
        if (accept) begin
            seen_next  = 1'b1;
            match_next = all_match;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg      <= IDLE;
            stab_reg       <= '0;
            miss_reg       <= '0;
            seen_reg       <= 1'b0;
            match_reg      <= 1'b0;
            locked_reg     <= 1'b0;
            addr_valid_reg <= 1'b0;
            enable_reg     <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                cand_reg[i] <= '0;
                out_reg[i]  <= '0;
            end
        end else begin
            state_reg      <= state_next;
            stab_reg       <= stab_next;
            miss_reg       <= miss_next;
            seen_reg       <= seen_next;
            match_reg      <= match_next;
            locked_reg     <= (state_next == LOCKED);
            addr_valid_reg <= pub;
            if (pub) enable_reg <= pub_en;
            for (int i = 0; i < 4; i++) begin
                if (accept)         cand_reg[i] <= new_c[i];
                if (pub && pub_cand) out_reg[i] <= cand_reg[i];
            end
        end
    end

    assign o_addr_valid = addr_valid_reg;
    assign o_ul_addr    = out_reg[0];
    assign o_ur_addr    = out_reg[1];
    assign o_dl_addr    = out_reg[2];
    assign o_dr_addr    = out_reg[3];
    assign o_enable     = enable_reg;
    assign o_locked     = locked_reg;
    assign o_stab_cnt   = stab_reg;

endmodule

// File: tb/tb_overlay_frame_ctrl.sv
// -----------------------------------------------------------------------------
// Directed testbench for overlay_frame_ctrl. Each test task drives frames and
// checks the publish pulse, corners, enable, lock and stability count against
// hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_overlay_frame_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_frame_start = 1'b0;
    logic        i_corner_valid = 1'b0;
    logic [19:0] i_ul = '0, i_ur = '0, i_dl = '0, i_dr = '0;
    logic        i_enable_sw = 1'b0;
    logic        i_pause_sw = 1'b0;
    logic        o_addr_valid;
    logic [19:0] o_ul_addr, o_ur_addr, o_dl_addr, o_dr_addr;
    logic        o_enable;
    logic        o_locked;
    logic [3:0]  o_stab_cnt;

    int checks = 0;
    int errors = 0;
    int frame_no = 0;
    logic av;

    overlay_frame_ctrl dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_frame_start(i_frame_start), .i_corner_valid(i_corner_valid),
        .i_ul(i_ul), .i_ur(i_ur), .i_dl(i_dl), .i_dr(i_dr),
        .i_enable_sw(i_enable_sw), .i_pause_sw(i_pause_sw),
        .o_addr_valid(o_addr_valid),
        .o_ul_addr(o_ul_addr), .o_ur_addr(o_ur_addr),
        .o_dl_addr(o_dl_addr), .o_dr_addr(o_dr_addr),
        .o_enable(o_enable), .o_locked(o_locked), .o_stab_cnt(o_stab_cnt)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [19:0] rc(input int r, input int c);
        logic [9:0] rr;
        logic [9:0] cc;
        rr = r[9:0];
        cc = c[9:0];
        return {rr, cc};
    endfunction

    // Advance one clock and settle 1 ns after the edge.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_corners(input int dr_off, input int dc_off);
        i_ul = rc(100 + dr_off, 100 + dc_off);
        i_ur = rc(100 + dr_off, 228 + dc_off);
        i_dl = rc(228 + dr_off, 100 + dc_off);
        i_dr = rc(228 + dr_off, 228 + dc_off);
        i_corner_valid = 1'b1;
        tick();
        i_corner_valid = 1'b0;
        tick();
    endtask

    // Pulse frame_start; av returns o_addr_valid one cycle later.
    task automatic frame(output logic avo);
        tick();
        i_frame_start = 1'b1;
        tick();
        i_frame_start = 1'b0;
        avo = o_addr_valid;
        frame_no++;
        $display("frame %0d: addr_valid=%0b enable=%0b locked=%0b stab=%0d ul=%h",
                 frame_no, avo, o_enable, o_locked, o_stab_cnt, o_ul_addr);
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        tick();
        tick();
        checks++; if (o_addr_valid !== 1'b0) begin errors++; $display("FAIL reset_av: got %b exp 0", o_addr_valid); end
        checks++; if (o_locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b exp 0", o_locked); end
        checks++; if (o_stab_cnt !== 4'd0) begin errors++; $display("FAIL reset_stab: got %0d exp 0", o_stab_cnt); end
        checks++; if (o_ul_addr !== 20'h0 || o_enable !== 1'b0) begin errors++; $display("FAIL reset_out: got ul=%h en=%b exp 0", o_ul_addr, o_enable); end
        #2 i_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_lock();
        i_enable_sw = 1'b1;
        for (int f = 1; f <= 3; f++) begin
            send_corners(0, 0);
            frame(av);
            checks++; if (av !== (f == 3)) begin errors++; $display("FAIL lock_av_f%0d: got %b exp %b", f, av, (f == 3)); end
            checks++; if (o_stab_cnt !== 4'(f)) begin errors++; $display("FAIL lock_stab_f%0d: got %0d exp %0d", f, o_stab_cnt, f); end
        end
        checks++; if (o_enable !== 1'b1 || o_locked !== 1'b1) begin errors++; $display("FAIL lock_state: got en=%b lk=%b exp 1 1", o_enable, o_locked); end
        checks++; if (o_ul_addr !== rc(100, 100) || o_dr_addr !== rc(228, 228)) begin errors++; $display("FAIL lock_corners: got ul=%h dr=%h exp %h %h", o_ul_addr, o_dr_addr, rc(100, 100), rc(228, 228)); end
        checks++; if (o_ur_addr !== rc(100, 228) || o_dl_addr !== rc(228, 100)) begin errors++; $display("FAIL lock_corners2: got ur=%h dl=%h", o_ur_addr, o_dl_addr); end
        send_corners(0, 0);
        frame(av);
        checks++; if (av !== 1'b1) begin errors++; $display("FAIL lock_repeat_av: got %b exp 1", av); end
        tick();
        checks++; if (o_addr_valid !== 1'b0) begin errors++; $display("FAIL lock_pulse_width: got %b exp 0", o_addr_valid); end
    endtask

    task automatic test_jump();
        send_corners(20, 0);
        frame(av);
        checks++; if (av !== 1'b0) begin errors++; $display("FAIL jump_av: got %b exp 0", av); end
        checks++; if (o_stab_cnt !== 4'd1 || o_locked !== 1'b1) begin errors++; $display("FAIL jump_state: got stab=%0d lk=%b exp 1 1", o_stab_cnt, o_locked); end
        checks++; if (o_ul_addr !== rc(100, 100)) begin errors++; $display("FAIL jump_hold: got %h exp %h", o_ul_addr, rc(100, 100)); end
        send_corners(20, 0);
        frame(av);
        checks++; if (av !== 1'b1 || o_ul_addr !== rc(120, 100)) begin errors++; $display("FAIL jump_resume: got av=%b ul=%h exp 1 %h", av, o_ul_addr, rc(120, 100)); end
        send_corners(20, 0);
        frame(av);
        checks++; if (av !== 1'b1 || o_stab_cnt !== 4'd3) begin errors++; $display("FAIL jump_stab: got av=%b stab=%0d exp 1 3", av, o_stab_cnt); end
    endtask

    task automatic test_lost();
        for (int f = 1; f <= 4; f++) begin
            frame(av);
            checks++; if (av !== (f == 4)) begin errors++; $display("FAIL lost_av_f%0d: got %b exp %b", f, av, (f == 4)); end
        end
        checks++; if (o_enable !== 1'b0 || o_locked !== 1'b0 || o_stab_cnt !== 4'd0) begin errors++; $display("FAIL lost_state: got en=%b lk=%b stab=%0d exp 0 0 0", o_enable, o_locked, o_stab_cnt); end
        checks++; if (o_ul_addr !== rc(120, 100)) begin errors++; $display("FAIL lost_hold: got %h exp %h", o_ul_addr, rc(120, 100)); end
    endtask

    task automatic test_reject();
        for (int f = 0; f < 6; f++) begin
            i_ul = rc(100, (f == 5) ? 200 : 300);
            i_ur = rc(100, 200);
            i_dl = rc(228, 100);
            i_dr = rc(228, 228);
            i_corner_valid = 1'b1;
            tick();
            i_corner_valid = 1'b0;
            frame(av);
            checks++; if (av !== 1'b0 || o_locked !== 1'b0 || o_stab_cnt !== 4'd0) begin errors++; $display("FAIL reject_f%0d: got av=%b lk=%b stab=%0d exp 0 0 0", f, av, o_locked, o_stab_cnt); end
        end
    endtask

    task automatic test_pause();
        // Candidate still holds the (120,100) set, so each frame matches.
        for (int f = 1; f <= 3; f++) begin
            send_corners(20, 0);
            frame(av);
            checks++; if (av !== (f == 3)) begin errors++; $display("FAIL relock_av_f%0d: got %b exp %b", f, av, (f == 3)); end
        end
        i_pause_sw = 1'b1;
        for (int f = 1; f <= 5; f++) begin
            send_corners(20, 2 * f);
            frame(av);
            checks++; if (av !== 1'b0 || o_stab_cnt !== 4'd3 || o_locked !== 1'b1) begin errors++; $display("FAIL pause_f%0d: got av=%b stab=%0d lk=%b exp 0 3 1", f, av, o_stab_cnt, o_locked); end
        end
        i_pause_sw = 1'b0;
        send_corners(20, 12);
        frame(av);
        checks++; if (av !== 1'b1 || o_ul_addr !== rc(120, 112) || o_enable !== 1'b1) begin errors++; $display("FAIL pause_release: got av=%b ul=%h en=%b exp 1 %h 1", av, o_ul_addr, o_enable, rc(120, 112)); end
    endtask

    task automatic test_coincident_and_reset();
        i_ul = rc(120, 112);
        i_ur = rc(120, 240);
        i_dl = rc(248, 112);
        i_dr = rc(248, 240);
        tick();
        i_corner_valid = 1'b1;
        i_frame_start = 1'b1;
        tick();
        i_corner_valid = 1'b0;
        i_frame_start = 1'b0;
        checks++; if (o_addr_valid !== 1'b0 || o_stab_cnt !== 4'd0 || o_locked !== 1'b1) begin errors++; $display("FAIL coinc_eval: got av=%b stab=%0d lk=%b exp 0 0 1", o_addr_valid, o_stab_cnt, o_locked); end
        frame(av);
        checks++; if (av !== 1'b1 || o_stab_cnt !== 4'd1) begin errors++; $display("FAIL coinc_next: got av=%b stab=%0d exp 1 1", av, o_stab_cnt); end
        send_corners(20, 12);
        #2 i_rst_n = 1'b0;
        #1;
        checks++; if (o_ul_addr !== 20'h0 || o_locked !== 1'b0 || o_stab_cnt !== 4'd0 || o_enable !== 1'b0) begin errors++; $display("FAIL async_reset: got ul=%h lk=%b stab=%0d en=%b exp 0", o_ul_addr, o_locked, o_stab_cnt, o_enable); end
        #3 i_rst_n = 1'b1;
        frame(av);
        checks++; if (av !== 1'b0 || o_locked !== 1'b0) begin errors++; $display("FAIL post_reset: got av=%b lk=%b exp 0 0", av, o_locked); end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_jump();
        test_lost();
        test_reject();
        test_pause();
        test_coincident_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
